// File: rtl/ram_lsu_bridge.sv
// ram_lsu_bridge
//   Bridges the core's load/store request channel to a byte-lane data RAM.
//   One request is in flight at a time. Each request is checked for alignment.
//   Stores drive a byte-lane write mask and lane-replicated data for one cycle.
//   Loads pulse the read enable, wait RD_LAT cycles, then extract, align and
//   extend the addressed lanes. Every request ends with one response.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; req_ready is combinational
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata  byte address, right-justified store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   load result (0 for stores/errors), error flag
//   ram_wen, ram_addr    byte write enables, byte address to the RAM
//   ram_wdata, ram_ren   write data, read enable to the RAM
//   ram_rdata            RAM read data, valid RD_LAT cycles after ram_ren
module ram_lsu_bridge #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_ren,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [3:0]    wen_nxt;
  logic          ren_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic          rsp_valid_nxt;
  logic [DW-1:0] rsp_rdata_nxt;
  logic          rsp_err_nxt;
  logic          capture;

  // Request fields held for the duration of the access
  logic          we_p0;
  logic [1:0]    size_p0;
  logic          uns_p0;
  logic [1:0]    off_p0;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] lane_data(input logic [1:0] size, input logic [DW-1:0] wdata);
    case (size)
      2'b00:   lane_data = {4{wdata[7:0]}};
      2'b01:   lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  function automatic logic [DW-1:0] load_fmt(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [DW-1:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(rdata[{off, 3'b000} +: 8]);
    h = $signed(rdata[{off[1], 4'b0000} +: 16]);
    case (size)
      2'b00:   load_fmt = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_fmt = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_fmt = rdata;
    endcase
  endfunction

  assign req_ready = (state == IDLE) && !rst;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wen_nxt       = 4'b0000;
    ren_nxt       = 1'b0;
    addr_nxt      = ram_addr;
    wdata_nxt     = ram_wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          capture = 1'b1;
          if (misaligned(req_size, req_addr[1:0])) begin
            // Rejected requests never touch the RAM
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end else begin
            // Strobes are registered here so they are live throughout ACCESS
            state_nxt = ACCESS;
            addr_nxt  = req_addr;
            if (req_we) begin
              wen_nxt   = lane_mask(req_size, req_addr[1:0]);
              wdata_nxt = lane_data(req_size, req_wdata);
            end else begin
              ren_nxt = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (we_p0) begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = '0;
        end else begin
          state_nxt = RD_WAIT;
          cnt_nxt   = 2'(RD_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (cnt == 2'd0) begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = load_fmt(size_p0, uns_p0, off_p0, ram_rdata);
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      ram_wen   <= 4'b0000;
      ram_ren   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ram_wen   <= wen_nxt;
      ram_ren   <= ren_nxt;
      ram_addr  <= addr_nxt;
      ram_wdata <= wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
    if (capture) begin
      we_p0   <= req_we;
      size_p0 <= req_size;
      uns_p0  <= req_unsigned;
      off_p0  <= req_addr[1:0];
    end
  end

endmodule

// File: tb/tb_ram_lsu_bridge.sv
// Bench for ram_lsu_bridge: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Each instance talks to its own small RAM model whose read data is random
// junk except in the one cycle the configured latency makes it valid.
module tb_ram_lsu_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       req_valid, req_ready, req_we, req_unsigned;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0]       rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0][3:0]  ram_wen;
  logic [1:0][31:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]       ram_ren;

  ram_lsu_bridge #(.AW(32), .DW(32), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .ram_wen(ram_wen[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_ren(ram_ren[0]), .ram_rdata(ram_rdata[0]));

  ram_lsu_bridge #(.AW(32), .DW(32), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .ram_wen(ram_wen[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_ren(ram_ren[1]), .ram_rdata(ram_rdata[1]));

  // RAM models: byte-lane writes, read pipeline of depth 1 / 3
  logic        mem_clr;
  logic [31:0] mem [2][16];
  logic [31:0] pd  [2][3];
  logic        pv  [2][3];
  logic [31:0] junk;

  always @(posedge clk) junk <= $urandom;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_clr) begin
        for (int w = 0; w < 16; w++) mem[i][w] <= 32'h0;
        for (int s = 0; s < 3; s++) pv[i][s] <= 1'b0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[i][b]) mem[i][ram_addr[i][5:2]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
        pv[i][0] <= ram_ren[i];
        pd[i][0] <= mem[i][ram_addr[i][5:2]];
        for (int s = 1; s < 3; s++) begin
          pv[i][s] <= pv[i][s-1];
          pd[i][s] <= pd[i][s-1];
        end
      end
    end
  end

  assign ram_rdata[0] = pv[0][0] ? pd[0][0] : junk;
  assign ram_rdata[1] = pv[1][2] ? pd[1][2] : ~junk;

  // Reference model: the memory image as the requester sees it
  logic [31:0] model_mem [2][16];
  int lat_cfg [2] = '{1, 3};

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int i, input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr);
    longint unsigned v, span;
    int nb;
    nb = 1 << size;
    v  = longint'(model_mem[i][addr[5:2]]) >> (8 * int'(addr % 4));
    if (nb < 4) begin
      span = 64'd1 << (8 * nb);
      v = v % span;
      if (!uns && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    end
    return v[31:0];
  endfunction

  task automatic ref_store(input int i, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int nb, a;
    logic [31:0] w;
    nb = 1 << size;
    for (int k = 0; k < nb; k++) begin
      a = int'(addr[5:0]) + k;
      w = model_mem[i][a / 4];
      w = (w & ~(32'hFF << (8 * (a % 4)))) | (((wdata >> (8 * k)) & 32'hFF) << (8 * (a % 4)));
      model_mem[i][a / 4] = w;
    end
  endtask

  function automatic logic [3:0] ref_mask(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] m;
    m = 4'b0;
    for (int k = 0; k < (1 << size); k++) m[(int'(addr % 4) + k) % 4] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'b00) return (w & 32'hFF) * 32'h01010101;
    if (size == 2'b01) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  wcnt;
    logic [7:0]  rcnt;
    logic [3:0]  wen_s;
    logic [31:0] wdata_s;
    logic [31:0] addr_s;
    logic        hold_ok;
    logic        rdy_after;
  } res_t;

  // One full transaction; called #1 after a rising edge.
  task automatic txn(input int i, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     input bit noise, output res_t r);
    int n;
    r = '0;
    req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = size;
    req_unsigned[i] = uns; req_addr[i] = addr; req_wdata[i] = wdata;
    n = 0;
    while (!req_ready[i] && n < 50) begin @(posedge clk); #1; n++; end
    chk("accepted", {31'b0, req_ready[i]}, 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n = 0;
    while (!rsp_valid[i] && n < 20) begin
      if (ram_wen[i] != 4'b0) begin
        r.wcnt++; r.wen_s = ram_wen[i]; r.wdata_s = ram_wdata[i]; r.addr_s = ram_addr[i];
      end
      if (ram_ren[i]) begin r.rcnt++; r.addr_s = ram_addr[i]; end
      rsp_ready[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1; n++;
    end
    rsp_ready[i] = 1'b0;
    chk("rsp_seen", {31'b0, rsp_valid[i]}, 32'd1);
    r.lat = 8'(n + 1);
    r.rdata = rsp_rdata[i];
    r.err = rsp_err[i];
    r.hold_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!rsp_valid[i] || rsp_rdata[i] !== r.rdata || rsp_err[i] !== r.err || req_ready[i]
          || ram_wen[i] != 4'b0 || ram_ren[i])
        r.hold_ok = 1'b0;
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    r.rdy_after = req_ready[i] && !rsp_valid[i];
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   i, n, hold, hi;
    logic we, uns, err;
    logic [1:0] size;
    logic [31:0] addr, wdata;

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h123456AB, 32'h0,        1'b0, 4'b1000, 32'hABABABAB};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'hFFFFFFAB, 1'b0, 4'b0000, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h000000AB, 1'b0, 4'b0000, 32'h0};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h55558001, 32'h0,        1'b0, 4'b1100, 32'h80018001};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'hFFFF8001, 1'b0, 4'b0000, 32'h0};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h00008001, 1'b0, 4'b0000, 32'h0};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h001, 32'h0000FFFF, 32'h0,        1'b1, 4'b0000, 32'h0};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b0, 4'b1111, 32'h12345678};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h12345678, 1'b0, 4'b0000, 32'h0};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'h00000056, 1'b0, 4'b0000, 32'h0};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'h00001234, 1'b0, 4'b0000, 32'h0};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h000000F0, 32'h0,        1'b0, 4'b0010, 32'hF0F0F0F0};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        32'hFFFFF078, 1'b0, 4'b0000, 32'h0};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 32'h102, 32'hCAFEBABE, 32'h0,        1'b1, 4'b0000, 32'h0};

    rst = 2'b11; mem_clr = 1'b1;
    req_valid = '0; req_we = '0; req_unsigned = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = '0;
    for (int k = 0; k < 2; k++) for (int w = 0; w < 16; w++) model_mem[k][w] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", {30'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid",  {30'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",    {30'b0, rsp_err}, 32'd0);
    chk("rst_rdata0",     rsp_rdata[0], 32'd0);
    chk("rst_rdata1",     rsp_rdata[1], 32'd0);
    chk("rst_wen",        {24'b0, ram_wen}, 32'd0);
    chk("rst_ren",        {30'b0, ram_ren}, 32'd0);
    chk("rst_addr",       ram_addr[0] | ram_addr[1], 32'd0);
    chk("rst_wdata",      ram_wdata[0] | ram_wdata[1], 32'd0);
    rst = 2'b00; mem_clr = 1'b0;
    #1;
    chk("ready_after_rst", {30'b0, req_ready}, 32'd3);
    @(posedge clk); #1;

    // Directed vectors on the RD_LAT=1 instance
    for (int v = 0; v < 16; v++) begin
      txn(0, tbl[v].we, tbl[v].size, tbl[v].uns, tbl[v].addr, tbl[v].wdata, 0, 1'b0, r);
      chk($sformatf("v%0d_err", v), {31'b0, r.err}, {31'b0, tbl[v].exp_err});
      chk($sformatf("v%0d_rdata", v), r.rdata, tbl[v].exp_rdata);
      chk($sformatf("v%0d_lat", v), {24'b0, r.lat},
          tbl[v].exp_err ? 32'd1 : (tbl[v].we ? 32'd2 : 32'd3));
      chk($sformatf("v%0d_wen", v), {28'b0, r.wen_s}, {28'b0, tbl[v].exp_wen});
      chk($sformatf("v%0d_wcnt", v), {24'b0, r.wcnt}, (tbl[v].exp_wen != 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_rcnt", v), {24'b0, r.rcnt},
          (!tbl[v].exp_err && !tbl[v].we) ? 32'd1 : 32'd0);
      if (tbl[v].exp_wen != 0) chk($sformatf("v%0d_wdata", v), r.wdata_s, tbl[v].exp_wdata);
      if (!tbl[v].exp_err) chk($sformatf("v%0d_addr", v), r.addr_s, tbl[v].addr);
      chk($sformatf("v%0d_rdy", v), {31'b0, r.rdy_after}, 32'd1);
      if (!tbl[v].exp_err && tbl[v].we) ref_store(0, tbl[v].size, tbl[v].addr, tbl[v].wdata);
    end

    // Backpressure: response held for 5 cycles
    txn(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 0, 1'b0, r);
    ref_store(0, 2'd2, 32'h100, 32'h12345678);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5, 1'b0, r);
    chk("bp_rdata", r.rdata, 32'h12345678);
    chk("bp_hold_stable", {31'b0, r.hold_ok}, 32'd1);
    chk("bp_ready_after", {31'b0, r.rdy_after}, 32'd1);

    // RD_LAT=3 instance
    txn(1, 1'b1, 2'd2, 1'b0, 32'h110, 32'h0BADF00D, 0, 1'b0, r);
    ref_store(1, 2'd2, 32'h110, 32'h0BADF00D);
    chk("l3_store_lat", {24'b0, r.lat}, 32'd2);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h110, 32'h0, 0, 1'b0, r);
    chk("l3_lat", {24'b0, r.lat}, 32'd5);
    chk("l3_rcnt", {24'b0, r.rcnt}, 32'd1);
    chk("l3_rdata", r.rdata, 32'h0BADF00D);
    txn(1, 1'b0, 2'd0, 1'b0, 32'h112, 32'h0, 0, 1'b0, r);
    chk("l3_byte", r.rdata, 32'hFFFFFFAD);

    // Reset while the RD_LAT=3 instance is waiting for read data
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2;
    req_unsigned[1] = 1'b0; req_addr[1] = 32'h110;
    n = 0;
    while (!req_ready[1] && n < 20) begin @(posedge clk); #1; n++; end
    chk("mid_rst_accept", {31'b0, req_ready[1]}, 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    chk("mid_rst_ready_low", {31'b0, req_ready[1]}, 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid[1]}, 32'd0);
    chk("mid_rst_ren", {31'b0, ram_ren[1]}, 32'd0);
    chk("mid_rst_wen", {28'b0, ram_wen[1]}, 32'd0);
    chk("mid_rst_addr", ram_addr[1], 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready[1]}, 32'd1);
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) hi++;
    end
    chk("mid_rst_no_rsp", hi, 32'd0);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h110, 32'h0, 0, 1'b0, r);
    chk("post_rst_rdata", r.rdata, 32'h0BADF00D);
    chk("post_rst_lat", {24'b0, r.lat}, 32'd5);

    // Randomized traffic against the reference model
    for (int t = 0; t < 150; t++) begin
      i = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      n = int'($urandom_range(0, 9));
      size = (n < 3) ? 2'd0 : (n < 6) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
      addr = 32'h100 + $urandom_range(0, 63);
      if (size != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 1);
      wdata = $urandom;
      hold = int'($urandom_range(0, 3));
      err = ref_err(size, addr);
      txn(i, we, size, uns, addr, wdata, hold, 1'b1, r);
      chk($sformatf("r%0d_err", t), {31'b0, r.err}, {31'b0, err});
      chk($sformatf("r%0d_rdata", t), r.rdata,
          (err || we) ? 32'h0 : ref_load(i, size, uns, addr));
      chk($sformatf("r%0d_lat", t), {24'b0, r.lat},
          err ? 32'd1 : (we ? 32'd2 : 32'(2 + lat_cfg[i])));
      chk($sformatf("r%0d_wcnt", t), {24'b0, r.wcnt}, (!err && we) ? 32'd1 : 32'd0);
      chk($sformatf("r%0d_rcnt", t), {24'b0, r.rcnt}, (!err && !we) ? 32'd1 : 32'd0);
      chk($sformatf("r%0d_hold", t), {31'b0, r.hold_ok}, 32'd1);
      chk($sformatf("r%0d_rdy", t), {31'b0, r.rdy_after}, 32'd1);
      if (!err && we) begin
        chk($sformatf("r%0d_wen", t), {28'b0, r.wen_s}, {28'b0, ref_mask(size, addr)});
        chk($sformatf("r%0d_wdata", t), r.wdata_s, ref_wdata(size, wdata));
        ref_store(i, size, addr, wdata);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_lsu_bridge.md
Name: ram_lsu_bridge

Overview:
- Sits between the core's load/store request channel and the byte-lane data RAM (4-bit byte write enable, byte address, 32-bit data, read enable, read data).
- Accepts one load or store per handshake and checks alignment.
- Stores: generates the byte-lane write mask and lane-replicated write data.
- Loads: waits the RAM read latency, then extracts, aligns and sign- or zero-extends the read data.
- Returns a response on a valid/ready channel.

Parameters:
- AW, 32, address width in bits. Byte address.
- DW, 32, data width. Fixed at 32; other values are unsupported.
- RD_LAT, 1, RAM read latency in cycles from the ram_ren cycle to ram_rdata being valid. Legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal size
- ram_wen  out  4  byte write enables to the RAM
- ram_addr  out  AW  byte address to the RAM (the RAM divides by 4 internally)
- ram_wdata  out  32  write data to the RAM
- ram_ren  out  1  read enable to the RAM
- ram_rdata  in  32  read data from the RAM

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - When rst is sampled high at a clk edge: state = IDLE, and req_ready=0 during the reset cycle.
  - Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_wen=0, ram_ren=0, ram_addr=0, ram_wdata=0, wait counter=0.
- All outputs except req_ready are registered. req_ready = (state==IDLE) && !rst.
- States: IDLE, ACCESS, RD_WAIT, RESP.
- IDLE:
  - On req_valid && req_ready, latch we, size, unsigned, addr and wdata.
  - Misaligned or illegal requests go to RESP with rsp_err=1 and rsp_rdata=0; no RAM strobe is ever issued. Misaligned means any of:
    - half with addr[0]=1
    - word with addr[1:0]!=0
    - size=11
  - Otherwise go to ACCESS.
- ACCESS lasts exactly one cycle. During it:
  - ram_addr = latched addr.
  - Store: ram_wen = mask and ram_ren = 0.
  - Load: ram_ren = 1 and ram_wen = 0.
- Store mask and data:
  - byte: mask = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: mask = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - word: mask = 1111; wdata = wdata.
- Outside ACCESS, ram_wen=0 and ram_ren=0; ram_addr and ram_wdata hold their last values.
- ACCESS exit:
  - Store goes to RESP with rsp_err=0 and rsp_rdata=0.
  - Load goes to RD_WAIT with the counter loaded to RD_LAT-1.
- RD_WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, sample ram_rdata and go to RESP. With RD_LAT=1, this is the cycle immediately after ACCESS.
- Load formatting:
  - byte: rdata[8*addr[1:0] +: 8].
  - half: rdata[16*addr[1] +: 16].
  - word: rdata as is.
  - Extend to 32 bits with zeros if unsigned, otherwise with the sign bit.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready=1.
  - On the rsp_ready cycle, clear rsp_valid and go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency from the accept edge to rsp_valid:
  - store: 2 cycles.
  - load: 2 + RD_LAT cycles.
  - error: 1 cycle.
- Throughput is one outstanding request; no pipelining.
- rsp_ready while not in RESP is ignored.
- req_valid while req_ready=0 is not captured; the requester must hold the request.
- Reset mid-operation:
  - Any in-flight request is dropped and no response is produced.
  - Strobes deassert at the reset edge; a write strobe already issued in ACCESS is not undone.

Test Plan:
- Byte store/load, RD_LAT=1: store byte 0x...AB at 0x103 → ram_wen=1000, ram_wdata=0xABABABAB for one cycle, rsp after 2 cycles with err=0. Load byte signed at 0x103 → rsp_rdata=0xFFFFFFAB; unsigned load → 0x000000AB.
- Half store/load: store half 0x8001 at 0x102 → ram_wen=1100, ram_wdata=0x80018001. Load half signed at 0x102 → 0xFFFF8001; unsigned → 0x00008001.
- Misaligned: load word at 0x101, store half at 0x001, size=11 → ram_wen=0 and ram_ren=0 throughout, rsp_err=1, rsp_rdata=0, rsp_valid one cycle after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load word from 0x100 (RAM word 0x12345678) → rsp_valid stays 1 with rdata stable at 0x12345678, req_ready=0. Release → req_ready=1 the next cycle.
- Read latency: RD_LAT=3, load word → ram_ren high exactly 1 cycle, rsp_valid 5 cycles after the accept edge, and the sampled data equals ram_rdata from 3 cycles after ram_ren.
- Reset: assert rst during RD_WAIT → next cycle rsp_valid=0, ram_ren=0, ram_wen=0. After release, req_ready=1 and the next request completes normally.
